dcache_wb: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the core's data-memory port and main memory.
- Accepts the core's synchronous-read protocol: address, byte write-enable, read-enable and write data in cycle N; read data in cycle N+1.
- Raises stall on a miss and runs line writeback and refill over a 128-bit valid/ready memory interface.

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_data_array.sv | 36 +++
 rtl/dcache_wb.sv | 214 +++++++++++++++++++++
 tb/tb_dcache_wb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the write-back data cache: FSM encoding, line
// geometry, memory request direction codes and index/tag width helpers.
package dcache_pkg;

  localparam int OFFSET_W = 4;    // byte offset inside a 16-byte line
  localparam int LINE_W   = 128;  // line width in bits
  localparam int WORDS    = 4;    // 32-bit words per line

  localparam logic RNW_READ  = 1'b1;
  localparam logic RNW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COMPARE   = 3'd1,
    S_WB_REQ    = 3'd2,
    S_FILL_REQ  = 3'd3,
    S_FILL_WAIT = 3'd4,
    S_REFILL    = 3'd5
  } state_t;

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_lines);
    return addr_w - OFFSET_W - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Line data storage: NUM_LINES x 128-bit RAM with one registered read port,
// one byte-masked write port, and write-first behaviour when both ports hit
// the same line in the same cycle.
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int IDX_W     = idx_w(NUM_LINES)
) (
  input  logic                clk,
  input  logic [IDX_W-1:0]    raddr,
  output logic [LINE_W-1:0]   rdata,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [LINE_W/8-1:0] wmask,
  input  logic [LINE_W-1:0]   wdata
);

  logic [LINE_W-1:0] mem [NUM_LINES];
  logic [LINE_W-1:0] merged;

  // Combine the stored line with the masked write bytes
  always_comb begin
    merged = mem[waddr];
    for (int b = 0; b < LINE_W / 8; b++) begin
      if (wmask[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
    end
  end

  // Masked write plus registered read; a colliding read sees the new bytes
  always_ff @(posedge clk) begin
    if (|wmask) mem[waddr] <= merged;
    if ((|wmask) && (raddr == waddr)) rdata <= merged;
    else                              rdata <= mem[raddr];
  end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
// Core side: request in cycle N, load data in cycle N+1, stall while a miss
// is being serviced. Memory side: one 128-bit line per request.
// Optional macro DCACHE_PERF_CNT_EN adds hit_count / miss_count outputs.
//
// Memory handshake: mem_req_valid together with mem_req_rnw, mem_req_addr and
// mem_req_data stay constant from the first cycle valid is high until the
// cycle in which mem_req_ready is also high; that cycle is the transfer.
// mem_resp_valid is a single-cycle pulse carrying the fill line and is only
// consumed while waiting for a fill.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          dcache_addr,
  input  logic                       dcache_re,
  input  logic [3:0]                 dcache_we,
  input  logic [31:0]                dcache_din,
  output logic [31:0]                dcache_dout,
  output logic                       stall,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_req_rnw,
  output logic [ADDR_W-OFFSET_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0]          mem_req_data,
  input  logic                       mem_resp_valid,
  input  logic [LINE_W-1:0]          mem_resp_data
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count
`endif
);

  localparam int IDX_W = idx_w(NUM_LINES);
  localparam int TAG_W = tag_w(ADDR_W, NUM_LINES);

  state_t state_q, state_d;

  logic [ADDR_W-1:2]    req_addr_q;
  logic [3:0]           req_we_q;
  logic [31:0]          req_din_q;
  logic [31:0]          dout_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         req_word;
  logic               req_store;
  logic               hit;
  logic               victim_dirty;
  logic               core_req;
  logic               accept;
  logic               fill_done;
  logic               store_hit;
  logic [IDX_W-1:0]   arr_raddr;
  logic [LINE_W-1:0]  arr_rdata;
  logic [LINE_W/8-1:0] arr_wmask;
  logic [LINE_W-1:0]  arr_wdata;
  logic [31:0]        rd_word;
  logic               unused_addr_lo;

  // Byte lane within a word is implied by the write enables
  assign unused_addr_lo = ^dcache_addr[1:0];

  assign req_idx      = req_addr_q[OFFSET_W +: IDX_W];
  assign req_tag      = req_addr_q[ADDR_W-1 -: TAG_W];
  assign req_word     = req_addr_q[3:2];
  assign req_store    = |req_we_q;
  assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
  assign core_req     = dcache_re || (|dcache_we);
  assign stall        = ((state_q == S_COMPARE) && !hit) || (state_q == S_WB_REQ) ||
                        (state_q == S_FILL_REQ) || (state_q == S_FILL_WAIT);
  assign accept       = !stall && core_req;
  assign fill_done    = (state_q == S_FILL_WAIT) && mem_resp_valid;
  assign store_hit    = (state_q == S_COMPARE) && hit && req_store;
  assign arr_raddr    = accept ? dcache_addr[OFFSET_W +: IDX_W] : req_idx;
  assign rd_word      = arr_rdata[{req_word, 5'd0} +: 32];

  dcache_data_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W)
  ) u_data (
    .clk   (clk),
    .raddr (arr_raddr),
    .rdata (arr_rdata),
    .waddr (req_idx),
    .wmask (arr_wmask),
    .wdata (arr_wdata)
  );

  // Next-state logic for the miss-handling FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (accept) state_d = S_COMPARE;
      S_COMPARE: begin
        if (!hit)        state_d = victim_dirty ? S_WB_REQ : S_FILL_REQ;
        else if (accept) state_d = S_COMPARE;
        else             state_d = S_IDLE;
      end
      S_WB_REQ:    if (mem_req_ready) state_d = S_FILL_REQ;
      S_FILL_REQ:  if (mem_req_ready) state_d = S_FILL_WAIT;
      S_FILL_WAIT: if (mem_resp_valid) state_d = S_REFILL;
      S_REFILL:    state_d = accept ? S_COMPARE : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Array writes: byte-masked store hit, or whole-line fill with store merge
  always_comb begin
    arr_wmask = '0;
    arr_wdata = {WORDS{req_din_q}};
    if (store_hit) begin
      for (int w = 0; w < WORDS; w++) begin
        if (req_word == w[1:0]) arr_wmask[w*4 +: 4] = req_we_q;
      end
    end else if (fill_done) begin
      arr_wmask = '1;
      for (int b = 0; b < LINE_W / 8; b++) begin
        if ((req_word == b[3:2]) && req_we_q[b[1:0]])
          arr_wdata[b*8 +: 8] = req_din_q[8*b[1:0] +: 8];
        else
          arr_wdata[b*8 +: 8] = mem_resp_data[b*8 +: 8];
      end
    end
  end

  // Load data: live word on a load hit or refill, otherwise the held value
  always_comb begin
    dcache_dout = dout_q;
    if (((state_q == S_COMPARE) && hit && !req_store) || (state_q == S_REFILL))
      dcache_dout = rd_word;
  end

  // Memory request fields, driven purely from state so they hold until ready
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_rnw   = RNW_READ;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    case (state_q)
      S_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rnw   = RNW_WRITE;
        mem_req_addr  = {tag_q[req_idx], req_idx};
        mem_req_data  = arr_rdata;
      end
      S_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = req_addr_q[ADDR_W-1:OFFSET_W];
      end
      default: ;
    endcase
  end

  // State, captured request and held load data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      req_we_q   <= '0;
      req_din_q  <= '0;
      dout_q     <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dcache_dout;
      if (accept) begin
        req_addr_q <= dcache_addr[ADDR_W-1:2];
        req_we_q   <= dcache_we;
        req_din_q  <= dcache_din;
      end
    end
  end

  // Line valid/dirty flags; cleared by reset so an abandoned miss leaves no trace
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (store_hit) begin
      dirty_q[req_idx] <= 1'b1;
    end else if (fill_done) begin
      valid_q[req_idx] <= 1'b1;
      dirty_q[req_idx] <= req_store;
    end
  end

  // Tag array; contents are meaningless while the matching valid bit is clear
  always_ff @(posedge clk) begin
    if (fill_done) tag_q[req_idx] <= req_tag;
  end

`ifdef DCACHE_PERF_CNT_EN
  // One hit or miss count per accepted request, at its compare cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == S_COMPARE) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Directed testbench for dcache_wb (NUM_LINES=64): cold miss, hit table with
// store/load bypass, dirty eviction with backpressure, store miss, and reset
// during a fill.
module tb_dcache_wb;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  dcache_addr = '0;
  logic         dcache_re = 1'b0;
  logic [3:0]   dcache_we = '0;
  logic [31:0]  dcache_din = '0;
  logic [31:0]  dcache_dout;
  logic         stall;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic         mem_req_rnw;
  logic [27:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_resp_valid = 1'b0;
  logic [127:0] mem_resp_data = '0;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  dcache_wb #(.NUM_LINES(64), .ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .dcache_addr    (dcache_addr),
    .dcache_re      (dcache_re),
    .dcache_we      (dcache_we),
    .dcache_din     (dcache_din),
    .dcache_dout    (dcache_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rnw    (mem_req_rnw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic        re;
    logic [3:0]  we;
    logic [31:0] din;
    logic        exp_stall;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a cycle; returns in its compare cycle
  task automatic issue(input logic [31:0] addr, input logic re, input logic [3:0] we,
                       input logic [31:0] din);
    dcache_addr = addr;
    dcache_re   = re;
    dcache_we   = we;
    dcache_din  = din;
    next();
    dcache_re   = 1'b0;
    dcache_we   = 4'h0;
  endtask

  // Wait (bounded) for a memory request, check it, then accept it
  task automatic serve(input string nm, input logic exp_rnw, input logic [27:0] exp_addr,
                       input logic [127:0] exp_data, input bit chk_data);
    bit found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      #1;
      if (mem_req_valid) found = 1'b1;
      else next();
    end
    chk({nm, "_seen"}, found, 1'b1);
    if (found) begin
      chk({nm, "_rnw"}, mem_req_rnw, exp_rnw);
      chk({nm, "_addr"}, mem_req_addr, exp_addr);
      if (chk_data) chk({nm, "_data"}, mem_req_data, exp_data);
      mem_req_ready = 1'b1;
      next();
      mem_req_ready = 1'b0;
    end
  endtask

  // In the fill-wait cycle: return the line; ends mid-way through the refill cycle
  task automatic respond(input logic [127:0] line);
    #1;
    chk("fill_wait_stall", stall, 1'b1);
    mem_resp_valid = 1'b1;
    mem_resp_data  = line;
    next();
    mem_resp_valid = 1'b0;
    #1;
  endtask

  localparam logic [127:0] LINE_1000 = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] LINE_MOD  = {32'hABCD0044, 32'h0000BEEF, 32'h22, 32'h55555555};
  localparam logic [127:0] LINE_1400 = {32'h4, 32'h3, 32'h2, 32'h1};
  localparam logic [127:0] LINE_2000 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] LINE_2000M = {32'hA3, 32'hA2, 32'hA1, 32'hDEADBEEF};
  localparam logic [127:0] LINE_3010 = {32'h7C, 32'h7B, 32'h7A, 32'h79};

  initial begin
    // Hit sequence on line 0x1000 = {0x44,0x33,0x22,0x11}
    vecs[0] = '{32'h1004, 1'b1, 4'h0, 32'h0,        1'b0, 32'h22};
    vecs[1] = '{32'h1000, 1'b1, 4'h0, 32'h0,        1'b0, 32'h11};
    vecs[2] = '{32'h1008, 1'b0, 4'h3, 32'h0000BEEF, 1'b0, 32'h11};
    vecs[3] = '{32'h1008, 1'b1, 4'h0, 32'h0,        1'b0, 32'h0000BEEF};
    vecs[4] = '{32'h100C, 1'b0, 4'hC, 32'hABCD0000, 1'b0, 32'h0000BEEF};
    vecs[5] = '{32'h100C, 1'b1, 4'h0, 32'h0,        1'b0, 32'hABCD0044};
    vecs[6] = '{32'h1000, 1'b1, 4'hF, 32'h55555555, 1'b0, 32'hABCD0044};
    vecs[7] = '{32'h1000, 1'b1, 4'h0, 32'h0,        1'b0, 32'h55555555};
    vecs[8] = '{32'h0,    1'b0, 4'h0, 32'h0,        1'b0, 32'h55555555};
    vecs[9] = '{32'h1004, 1'b1, 4'h0, 32'h0,        1'b0, 32'h22};

    // Reset
    repeat (3) next();
    reset = 1'b0;
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_dout", dcache_dout, 32'h0);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_req_rnw", mem_req_rnw, 1'b1);
    chk("rst_req_addr", mem_req_addr, 28'h0);
    chk("rst_req_data", mem_req_data, 128'h0);
    next();

    // Cold load miss
    issue(32'h0000_1004, 1'b1, 4'h0, 32'h0);
    #1;
    chk("cold_cmp_stall", stall, 1'b1);
    next();
    serve("cold_fill", 1'b1, 28'h0000100, '0, 1'b0);
    respond(LINE_1000);
    chk("cold_refill_stall", stall, 1'b0);
    chk("cold_refill_dout", dcache_dout, 32'h22);
    next();

    // Back-to-back hits, store/load bypass, hold on store and idle cycles
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        dcache_addr = vecs[i].addr;
        dcache_re   = vecs[i].re;
        dcache_we   = vecs[i].we;
        dcache_din  = vecs[i].din;
      end else begin
        dcache_re = 1'b0;
        dcache_we = 4'h0;
      end
      #1;
      if (i > 0) begin
        chk($sformatf("vec%0d_stall", i - 1), stall, vecs[i-1].exp_stall);
        chk($sformatf("vec%0d_dout", i - 1), dcache_dout, vecs[i-1].exp_dout);
      end
      next();
    end

    // Dirty eviction with 5 cycles of backpressure on the writeback
    issue(32'h0000_1400, 1'b1, 4'h0, 32'h0);
    #1;
    chk("evict_cmp_stall", stall, 1'b1);
    next();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("wb_hold%0d_ctl", k), {stall, mem_req_valid, mem_req_rnw, mem_req_addr},
          {1'b1, 1'b1, 1'b0, 28'h0000100});
      chk($sformatf("wb_hold%0d_data", k), mem_req_data, LINE_MOD);
      next();
    end
    serve("evict_wb", 1'b0, 28'h0000100, LINE_MOD, 1'b1);
    serve("evict_fill", 1'b1, 28'h0000140, '0, 1'b0);
    respond(LINE_1400);
    chk("evict_refill_dout", dcache_dout, 32'h1);
    next();

    // Store miss on a clean victim: no writeback, merged line becomes dirty
    issue(32'h0000_2000, 1'b0, 4'hF, 32'hDEADBEEF);
    #1;
    chk("smiss_cmp_stall", stall, 1'b1);
    next();
    serve("smiss_fill", 1'b1, 28'h0000200, '0, 1'b0);
    respond(LINE_2000);
    chk("smiss_refill_stall", stall, 1'b0);
    next();
    issue(32'h0000_2000, 1'b1, 4'h0, 32'h0);
    #1;
    chk("smiss_load_stall", stall, 1'b0);
    chk("smiss_load_dout", dcache_dout, 32'hDEADBEEF);
    next();
    issue(32'h0000_1004, 1'b1, 4'h0, 32'h0);
    #1;
    chk("reload_cmp_stall", stall, 1'b1);
    next();
    serve("reload_wb", 1'b0, 28'h0000200, LINE_2000M, 1'b1);
    serve("reload_fill", 1'b1, 28'h0000100, '0, 1'b0);
    respond(LINE_MOD);
    chk("reload_refill_dout", dcache_dout, 32'h22);
    next();

    // Reset while waiting for fill data
    issue(32'h0000_3014, 1'b1, 4'h0, 32'h0);
    #1;
    chk("rfw_cmp_stall", stall, 1'b1);
    next();
    serve("rfw_fill", 1'b1, 28'h0000301, '0, 1'b0);
    reset = 1'b1;
    next();
    reset = 1'b0;
    #1;
    chk("rfw_post_stall", stall, 1'b0);
    chk("rfw_post_req_valid", mem_req_valid, 1'b0);
    next();
    issue(32'h0000_3014, 1'b1, 4'h0, 32'h0);
    #1;
    chk("rfw_again_stall", stall, 1'b1);
    next();
    serve("rfw_again_fill", 1'b1, 28'h0000301, '0, 1'b0);
    respond(LINE_3010);
    chk("rfw_again_dout", dcache_dout, 32'h7A);
    next();
    // Line 0x1000 was valid before reset; it must miss now
    issue(32'h0000_1004, 1'b1, 4'h0, 32'h0);
    #1;
    chk("post_rst_miss_stall", stall, 1'b1);
    next();
    serve("post_rst_fill", 1'b1, 28'h0000100, '0, 1'b0);
    respond(LINE_1000);
    chk("post_rst_dout", dcache_dout, 32'h22);
    next();

`ifdef DCACHE_PERF_CNT_EN
    #1;
    chk("perf_hit_count", hit_count, 32'd0);
    chk("perf_miss_count", miss_count, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
